// File: rtl/kmeans_seq_ctrl.sv
// Phase sequencer for the k-means core: header parse, point load, assign/update
// iterations until convergence or the iteration limit, then centroid readout.
module kmeans_seq_ctrl #(
  parameter int AW = 8,
  parameter int KW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          busy,
  output logic          pt_we,
  output logic [AW-1:0] pt_addr,
  output logic [DW-1:0] pt_wdata,
  output logic          cen_init,
  output logic          pt_rd,
  output logic          pt_last,
  input  logic          dp_assign_done,
  input  logic          dp_changed,
  output logic          upd_start,
  input  logic          dp_upd_done,
  output logic          cen_rd,
  output logic [KW-1:0] cen_idx,
  input  logic [DW-1:0] cen_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT, S_ASSIGN, S_A_WAIT,
    S_UPDATE, S_U_WAIT, S_OUT_RD, S_OUT_WAIT, S_OUT_FIN
  } state_t;

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] n_last_r;
  logic [KW-1:0] k_last_r;
  logic [4:0]    iter_r;
  logic [4:0]    max_it_r;
  logic          busy_r, pt_we_r, cen_init_r, pt_rd_r, pt_last_r;
  logic          upd_start_r, cen_rd_r, out_valid_r;
  logic [AW-1:0] pt_addr_r;
  logic [DW-1:0] pt_wdata_r;
  logic [KW-1:0] cen_idx_r;

  logic [KW-1:0] hdr_k_s;
  logic [3:0]    hdr_it_s;
  logic [AW-1:0] hdr_n_s;
  logic [KW-1:0] hdr_k_last_s;

  assign hdr_k_s  = in_data[DW-1 -: KW];
  assign hdr_it_s = in_data[AW+3:AW];
  assign hdr_n_s  = in_data[AW-1:0];

  // Header decode: clamp K-1 to N-1 when more clusters than points are requested
  always_comb begin
    hdr_k_last_s = hdr_k_s;
    if ({{(AW-KW){1'b0}}, hdr_k_s} > hdr_n_s) begin
      hdr_k_last_s = hdr_n_s[KW-1:0];
    end else begin
      hdr_k_last_s = hdr_k_s;
    end
  end

  // Sequencer FSM with all strobes registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      idx_r       <= {AW{1'b0}};
      n_last_r    <= {AW{1'b0}};
      k_last_r    <= {KW{1'b0}};
      iter_r      <= 5'd0;
      max_it_r    <= 5'd0;
      busy_r      <= 1'b0;
      pt_we_r     <= 1'b0;
      pt_addr_r   <= {AW{1'b0}};
      pt_wdata_r  <= {DW{1'b0}};
      cen_init_r  <= 1'b0;
      pt_rd_r     <= 1'b0;
      pt_last_r   <= 1'b0;
      upd_start_r <= 1'b0;
      cen_rd_r    <= 1'b0;
      cen_idx_r   <= {KW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      pt_we_r     <= 1'b0;
      cen_init_r  <= 1'b0;
      pt_rd_r     <= 1'b0;
      pt_last_r   <= 1'b0;
      upd_start_r <= 1'b0;
      cen_rd_r    <= 1'b0;
      // centroid data arrives one cycle after its strobe, so valid just trails cen_rd
      out_valid_r <= cen_rd_r;
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            n_last_r <= hdr_n_s;
            k_last_r <= hdr_k_last_s;
            max_it_r <= (hdr_it_s == 4'd0) ? 5'd16 : {1'b0, hdr_it_s};
            idx_r    <= {AW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            pt_we_r    <= 1'b1;
            pt_addr_r  <= idx_r;
            pt_wdata_r <= in_data;
            if (idx_r == n_last_r) begin
              idx_r   <= {AW{1'b0}};
              state_r <= S_INIT;
            end else begin
              idx_r <= idx_r + ONE_A;
            end
          end
        end
        S_INIT: begin
          cen_init_r <= 1'b1;
          iter_r     <= 5'd0;
          state_r    <= S_ASSIGN;
        end
        S_ASSIGN: begin
          pt_rd_r   <= 1'b1;
          pt_addr_r <= idx_r;
          if (idx_r == n_last_r) begin
            pt_last_r <= 1'b1;
            idx_r     <= {AW{1'b0}};
            state_r   <= S_A_WAIT;
          end else begin
            idx_r <= idx_r + ONE_A;
          end
        end
        S_A_WAIT: begin
          if (dp_assign_done) begin
            state_r <= dp_changed ? S_UPDATE : S_OUT_RD;
          end
        end
        S_UPDATE: begin
          upd_start_r <= 1'b1;
          state_r     <= S_U_WAIT;
        end
        S_U_WAIT: begin
          if (dp_upd_done) begin
            iter_r  <= iter_r + 5'd1;
            state_r <= (iter_r + 5'd1 == max_it_r) ? S_OUT_RD : S_ASSIGN;
          end
        end
        S_OUT_RD: begin
          cen_rd_r  <= 1'b1;
          cen_idx_r <= idx_r[KW-1:0];
          if (idx_r[KW-1:0] == k_last_r) begin
            idx_r   <= {AW{1'b0}};
            state_r <= S_OUT_WAIT;
          end else begin
            idx_r <= idx_r + ONE_A;
          end
        end
        S_OUT_WAIT: begin
          state_r <= S_OUT_FIN;
        end
        S_OUT_FIN: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign pt_we     = pt_we_r;
  assign pt_addr   = pt_addr_r;
  assign pt_wdata  = pt_wdata_r;
  assign cen_init  = cen_init_r;
  assign pt_rd     = pt_rd_r;
  assign pt_last   = pt_last_r;
  assign upd_start = upd_start_r;
  assign cen_rd    = cen_rd_r;
  assign cen_idx   = cen_idx_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_valid_r ? cen_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_kmeans_seq_ctrl.sv
// Randomised bench for kmeans_seq_ctrl: a transaction-level model predicts the
// writes, pass count, update count and readout of each job; a compare process checks every cycle.
module tb_kmeans_seq_ctrl;
  localparam int AW = 8;
  localparam int KW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          busy, pt_we, cen_init, pt_rd, pt_last, upd_start, cen_rd, out_valid;
  logic [AW-1:0] pt_addr;
  logic [DW-1:0] pt_wdata, out_data;
  logic [KW-1:0] cen_idx;
  logic          dp_assign_done = 1'b0, dp_changed = 1'b0, dp_upd_done = 1'b0;
  logic [DW-1:0] cen_rdata = '0;

  always #5 clk = ~clk;

  kmeans_seq_ctrl #(.AW(AW), .KW(KW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .busy(busy),
    .pt_we(pt_we), .pt_addr(pt_addr), .pt_wdata(pt_wdata), .cen_init(cen_init),
    .pt_rd(pt_rd), .pt_last(pt_last), .dp_assign_done(dp_assign_done),
    .dp_changed(dp_changed), .upd_start(upd_start), .dp_upd_done(dp_upd_done),
    .cen_rd(cen_rd), .cen_idx(cen_idx), .cen_rdata(cen_rdata),
    .out_valid(out_valid), .out_data(out_data)
  );

  int total = 0;
  int bad = 0;

  // job model
  int m_k = 1, m_n = 1, m_max = 1, m_passes = 0, m_ups = 0;
  logic [DW-1:0] exp_wdata [256];
  logic [DW-1:0] cen_mem [16];
  bit chg [16];
  // observed counters
  int w_cnt = 0, rd_cnt = 0, upd_cnt = 0, init_cnt = 0, cr_cnt = 0, ov_cnt = 0;
  // datapath model state
  int dp_pass = 0;
  bit dp_auto = 1'b1;
  bit force_late = 1'b0;
  bit pend_v = 1'b0;
  int pend_i = 0;
  int a_cnt = 0, u_cnt = 0;
  // previous-cycle observations
  bit p_we_last = 1'b0, p_rd = 1'b0, p_last = 1'b0, p_cr = 1'b0, p_ov = 1'b0;
  int p_cidx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setup_job(input logic [15:0] h, input logic [15:0] mask);
    m_n = int'(h[7:0]) + 1;
    m_k = int'(h[15:12]) + 1;
    if (m_k > m_n) m_k = m_n;
    m_max = (h[11:8] == 4'd0) ? 16 : int'(h[11:8]);
    for (int i = 0; i < 16; i++) chg[i] = mask[i];
    m_passes = 0;
    m_ups = 0;
    while (1) begin
      m_passes++;
      if (!chg[m_passes-1]) break;
      m_ups++;
      if (m_ups == m_max) break;
    end
    for (int i = 0; i < 256; i++) exp_wdata[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) cen_mem[i] = 16'($urandom);
    w_cnt = 0; rd_cnt = 0; upd_cnt = 0; init_cnt = 0; cr_cnt = 0; ov_cnt = 0;
    dp_pass = 0;
  endtask

  task automatic drive_load(input logic [15:0] h, input int gmax);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = h;
    for (int i = 0; i < m_n; i++) begin
      int g;
      g = $urandom_range(0, gmax);
      repeat (g) begin
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 16'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = exp_wdata[i];
    end
  endtask

  task automatic wait_done();
    int cyc;
    bit stop;
    bit fin;
    cyc = 0; stop = 1'b0; fin = 1'b0;
    while (cyc < 20000 && !fin) begin
      @(posedge clk); #1;
      cyc++;
      if (cen_rd) stop = 1'b1;
      if (!stop) begin
        in_valid = 1'($urandom); in_data = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (stop && !busy) fin = 1'b1;
    end
    in_valid = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL job_timeout: busy=%0b after %0d cycles, required busy=0", busy, cyc);
    end
    chk("job_init_cnt", init_cnt, 1);
    chk("job_writes", w_cnt, m_n);
    chk("job_reads", rd_cnt, m_passes * m_n);
    chk("job_updates", upd_cnt, m_ups);
    chk("job_cen_rd", cr_cnt, m_k);
    chk("job_out_words", ov_cnt, m_k);
    repeat (2) @(posedge clk);
  endtask

  task automatic run_job(input logic [15:0] h, input logic [15:0] mask, input int gmax);
    setup_job(h, mask);
    drive_load(h, gmax);
    wait_done();
  endtask

  // datapath model: done handshakes, spurious/simultaneous dones, synchronous centroid read
  initial begin
    forever begin
      @(posedge clk); #1;
      dp_assign_done = 1'b0; dp_upd_done = 1'b0; dp_changed = 1'($urandom);
      cen_rdata = pend_v ? cen_mem[pend_i] : 16'($urandom);
      pend_v = cen_rd; pend_i = int'(cen_idx);
      if (!rst_n) begin
        a_cnt = 0; u_cnt = 0; pend_v = 1'b0;
      end else begin
        if (force_late) begin
          dp_assign_done = 1'b1; dp_changed = 1'b1; force_late = 1'b0;
        end
        if (a_cnt > 0) begin
          a_cnt--;
          if (a_cnt == 0) begin
            dp_assign_done = 1'b1; dp_changed = chg[dp_pass % 16]; dp_pass++;
            if ($urandom_range(0, 1) == 1) dp_upd_done = 1'b1;
          end
        end
        if (u_cnt > 0) begin
          u_cnt--;
          if (u_cnt == 0) begin
            dp_upd_done = 1'b1;
            if ($urandom_range(0, 1) == 1) dp_assign_done = 1'b1;
          end
        end
        if (pt_last && dp_auto) a_cnt = $urandom_range(1, 4);
        if (upd_start) u_cnt = $urandom_range(1, 4);
        if (pt_rd && !pt_last && a_cnt == 0 && u_cnt == 0 && $urandom_range(0, 3) == 0) begin
          dp_assign_done = 1'b1; dp_upd_done = 1'($urandom);
        end
      end
    end
  end

  // per-cycle compare against the job model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_ctrl", {busy, pt_we, cen_init, pt_rd, pt_last, upd_start, cen_rd, out_valid}, 0);
        chk("reset_addr", {pt_addr, cen_idx}, 0);
        chk("reset_data", {pt_wdata, out_data}, 0);
        p_we_last = 1'b0; p_rd = 1'b0; p_last = 1'b0; p_cr = 1'b0; p_ov = 1'b0; p_cidx = 0;
      end else begin
        if (pt_we) begin
          chk("wr_addr", pt_addr, w_cnt);
          chk("wr_data", pt_wdata, exp_wdata[w_cnt % 256]);
          w_cnt++;
        end
        chk("cen_init_timing", cen_init, p_we_last);
        if (cen_init) init_cnt++;
        if (p_rd && !p_last) chk("rd_contig", pt_rd, 1);
        if (pt_rd) begin
          chk("rd_addr", pt_addr, rd_cnt % m_n);
          chk("rd_last", pt_last, (rd_cnt % m_n) == m_n - 1);
          chk("rd_after_init", init_cnt, 1);
          rd_cnt++;
        end else begin
          chk("last_without_rd", pt_last, 0);
        end
        if (upd_start) begin
          chk("upd_after_pass", rd_cnt, (upd_cnt + 1) * m_n);
          upd_cnt++;
        end
        if (p_cr && p_cidx != m_k - 1) chk("cr_contig", cen_rd, 1);
        if (cen_rd) begin
          chk("cr_idx", cen_idx, cr_cnt);
          chk("cr_after_passes", rd_cnt, m_passes * m_n);
          chk("cr_upd_count", upd_cnt, m_ups);
          cr_cnt++;
        end
        chk("ov_follow", out_valid, p_cr);
        chk("out_data", out_data, p_cr ? cen_mem[p_cidx] : 16'h0000);
        if (out_valid) begin
          chk("busy_with_ov", busy, 1);
          ov_cnt++;
        end
        if (p_ov && !out_valid) begin
          chk("busy_fall", busy, 0);
          chk("ov_count_at_end", ov_cnt, m_k);
        end
        p_we_last = pt_we && (w_cnt == m_n);
        p_rd = pt_rd; p_last = pt_last; p_cr = cen_rd; p_cidx = int'(cen_idx); p_ov = out_valid;
      end
    end
  end

  initial begin
    int seen;
    logic [15:0] h;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // reset in the middle of loading, then a normal job with the same header
    setup_job(16'h1203, 16'hFFFF);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h1203;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_data = exp_wdata[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("busy_in_reset", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_reset", busy, 0);
    run_job(16'h1203, 16'hFFFF, 2);
    chk("lit_1203_reads", rd_cnt, 8);
    chk("lit_1203_upds", upd_cnt, 2);

    // early convergence on the second pass
    run_job(16'h1203, 16'h0001, 3);
    chk("lit_conv_reads", rd_cnt, 8);
    chk("lit_conv_upds", upd_cnt, 1);
    chk("lit_conv_words", ov_cnt, 2);

    // iteration limit of one
    run_job(16'h3105, 16'hFFFF, 1);
    chk("lit_3105_upds", upd_cnt, 1);
    chk("lit_3105_reads", rd_cnt, 6);
    chk("lit_3105_words", ov_cnt, 4);

    // K clamped to N, MAX_IT field 0 meaning 16
    run_job(16'hF002, 16'hFFFF, 0);
    chk("lit_clamp_cen_rd", cr_cnt, 3);
    chk("lit_clamp_words", ov_cnt, 3);
    chk("lit_clamp_upds", upd_cnt, 16);

    // reset while waiting for assignment, followed by a late done
    dp_auto = 1'b0;
    setup_job(16'h1203, 16'hFFFF);
    drive_load(16'h1203, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (pt_last) seen = 1;
    end
    chk("awaits_pt_last_seen", seen, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    force_late = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("late_upd_start", upd_start, 0);
      chk("late_out_valid", out_valid, 0);
      chk("late_busy", busy, 0);
    end
    dp_auto = 1'b1;

    // randomised jobs
    for (int j = 0; j < 12; j++) begin
      h = {4'($urandom), 4'($urandom), 8'($urandom_range(0, 24))};
      run_job(h, 16'($urandom) | 16'h0001, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kmeans_seq_ctrl.md
Name: kmeans_seq_ctrl

Overview:
Top-level sequencer for the k-means CORE datapath. It parses the input header, streams points into point memory and pulses centroid initialisation. It then alternates assignment and update passes until convergence or the iteration limit, and finally streams the K centroids out on out_valid/out_data. It owns all phase sequencing; distance, accumulation and division stay in the datapath.

Parameters:
AW, 8, point-index width (N up to 2^AW)
KW, 4, cluster-index width (K up to 2^KW)
DW, 16, data word width; AW+KW+4 must equal DW

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word qualifier
in_data  input  DW  header word, then N packed points
busy  output  1  high in every state except IDLE
pt_we  output  1  point memory write enable
pt_addr  output  AW  point memory address (write in LOAD, read in ASSIGN)
pt_wdata  output  DW  point write data
cen_init  output  1  one-cycle pulse: datapath copies points 0..K-1 into centroids
pt_rd  output  1  assignment read strobe (one point per cycle)
pt_last  output  1  high with pt_rd on point N-1
dp_assign_done  input  1  datapath finished labelling all points
dp_changed  input  1  any label changed; sampled only with dp_assign_done
upd_start  output  1  one-cycle pulse: recompute centroids
dp_upd_done  input  1  centroid update finished
cen_rd  output  1  centroid read strobe
cen_idx  output  KW  centroid read index
cen_rdata  input  DW  centroid data, valid 1 cycle after cen_rd
out_valid  output  1  result word valid
out_data  output  DW  result word; 0 when out_valid low

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0, all counters 0. Reset at any point, including mid-ASSIGN or mid-OUT, aborts immediately with no further strobes.
- Header (first in_valid word in IDLE): K = in_data[15:12]+1; MAX_IT = in_data[11:8], where 0 means 16; N = in_data[7:0]+1. If K > N, K is clamped to N. IDLE -> LOAD.
- LOAD: each in_valid word i (i = 0..N-1) produces pt_we=1, pt_addr=i, pt_wdata=word one cycle after sampling. Gaps in in_valid are allowed; the index advances only on in_valid. After word N-1 -> INIT.
- INIT: cen_init high 1 cycle, iter=0 -> ASSIGN.
- ASSIGN: N consecutive cycles of pt_rd=1, pt_addr=0..N-1; pt_last with addr N-1 -> A_WAIT.
- A_WAIT: hold until dp_assign_done. If dp_changed=0 -> OUT_RD (converged, no update). Else -> UPDATE.
- UPDATE: upd_start 1 cycle -> U_WAIT.
- U_WAIT: on dp_upd_done, iter++. If iter == MAX_IT -> OUT_RD, else -> ASSIGN.
- OUT_RD: K consecutive cycles cen_rd=1, cen_idx=0..K-1. out_valid/out_data=cen_rdata follow each strobe by exactly 1 cycle, giving K contiguous out_valid cycles. After the last out_valid -> IDLE, busy=0.
- in_valid outside IDLE/LOAD is ignored. Done inputs outside their wait states are ignored.
- Simultaneous dp_assign_done and dp_upd_done: only the one matching the current state acts.
- dp_changed is never sampled on the first pass's behalf by the controller. The datapath guarantees changed=1 on the first pass, since initial labels are invalid.
- Iteration counter is 5 bits. There is no wrap, because the limit is ≤ 16.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0, busy=0. Header 0x1203 then accepted normally after release.
- Load with gaps: header 0x1203 (K=2, MAX_IT=2, N=4), 4 points with idle cycles between -> pt_we exactly 4 times, addr 0,1,2,3, data matches; cen_init 1 cycle after the last write.
- Early convergence: dp_changed=1 on pass 1, 0 on pass 2 -> exactly 1 upd_start, 2 ASSIGN bursts of 4 pt_rd, then 2 out_valid words equal to cen_rdata for idx 0,1.
- Iteration limit: header 0x3105 (K=4, MAX_IT=1, N=6), dp_changed always 1 -> 1 update, then 4 out_valid words, busy falls the cycle after the last.
- K clamp: header 0xF002 (K=16, N=3) -> cen_rd for idx 0..2 only, 3 out_valid words.
- Reset mid-A_WAIT: rst_n low while waiting, then a late dp_assign_done -> no upd_start and no out_valid; controller stays in IDLE.
